// File: rtl/ram_dp_clr.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only, and a built-in clear sequencer.
// Optional macro RAM_DP_CLR_OUTREG_EN adds an output register stage on a_q and b_q (read latency 2).
module ram_dp_clr #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clr_req,
    output logic                             busy,
    input  logic [ADDR_WIDTH-1:0]            a_address,
    input  logic [DATA_WIDTH-1:0]            a_data,
    input  logic                             a_wren,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_byteen,
    output logic [DATA_WIDTH-1:0]            a_q,
    input  logic [ADDR_WIDTH-1:0]            b_address,
    output logic [DATA_WIDTH-1:0]            b_q
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   a_rd_q, a_rd_d;
    logic [DATA_WIDTH-1:0]   b_rd_q, b_rd_d;
    logic [DATA_WIDTH-1:0]   a_old, a_merged;
    logic                    a_wr;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // State register, including the registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            a_rd_q  <= a_rd_d;
            b_rd_q  <= b_rd_d;
        end
    end

    // Next-state logic: clear sweeps every address once, then returns to idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Output and datapath logic
    always_comb begin
        busy_d   = (state_d == S_CLEAR);
        a_old    = mem[a_address];
        a_merged = a_old;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (a_byteen[i]) begin
                a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        a_wr   = (state_q == S_IDLE) && a_wren && (|a_byteen);
        a_rd_d = '0;
        b_rd_d = '0;
        if (state_q == S_IDLE) begin
            a_rd_d = (a_wren && (RDW_MODE == 0)) ? a_merged : a_old;
            b_rd_d = mem[b_address];
        end
    end

    // Array write port; contents are left untouched while reset is held
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                mem[cnt_q] <= FILL_VALUE;
            end else if (a_wr) begin
                mem[a_address] <= a_merged;
            end
        end
    end

    assign busy = busy_q;

`ifdef RAM_DP_CLR_OUTREG_EN
    logic [DATA_WIDTH-1:0] a_out_q, b_out_q;

    // Second read stage, forced to zero while clearing
    always_ff @(posedge clock) begin
        if (reset || (state_q == S_CLEAR)) begin
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            a_out_q <= a_rd_q;
            b_out_q <= b_rd_q;
        end
    end

    assign a_q = a_out_q;
    assign b_q = b_out_q;
`else
    assign a_q = a_rd_q;
    assign b_q = b_rd_q;
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: one instance per read-during-write mode, driven in lockstep
// and checked against a behavioural memory model through a latency-aligned scoreboard queue.
module tb_ram_dp_clr;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [DW-1:0] FILL = 16'h00A5;
`ifdef RAM_DP_CLR_OUTREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    typedef struct {
        string         tag;
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        logic [DW-1:0] b;
        bit            la_en;
        logic [DW-1:0] la0;
        logic [DW-1:0] la1;
        bit            lb_en;
        logic [DW-1:0] lb;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          clr_req;
    logic [AW-1:0] a_address;
    logic [DW-1:0] a_data;
    logic          a_wren;
    logic [1:0]    a_byteen;
    logic [AW-1:0] b_address;
    logic          busy0, busy1;
    logic [DW-1:0] a_q0, a_q1, b_q0, b_q1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mdl [DEPTH];
    bit            m_clear = 1'b0;
    int            m_cnt   = 0;
    exp_t          sb[$];

    bit            lit_a_en = 1'b0;
    logic [DW-1:0] lit_a0, lit_a1;
    bit            lit_b_en = 1'b0;
    logic [DW-1:0] lit_b;

    ram_dp_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RDW_MODE(0), .FILL_VALUE(FILL)) dut0 (
        .clock(clock), .reset(reset), .clr_req(clr_req), .busy(busy0),
        .a_address(a_address), .a_data(a_data), .a_wren(a_wren), .a_byteen(a_byteen),
        .a_q(a_q0), .b_address(b_address), .b_q(b_q0)
    );

    ram_dp_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RDW_MODE(1), .FILL_VALUE(FILL)) dut1 (
        .clock(clock), .reset(reset), .clr_req(clr_req), .busy(busy1),
        .a_address(a_address), .a_data(a_data), .a_wren(a_wren), .a_byteen(a_byteen),
        .a_q(a_q1), .b_address(b_address), .b_q(b_q1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, and check whatever output is due
    task automatic step(input bit rst, input bit clr, input bit we, input logic [1:0] be,
                        input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic [AW-1:0] ba, input string tag);
        exp_t          e;
        logic [DW-1:0] old, mrg;
        bit            nclear;
        reset = rst; clr_req = clr; a_wren = we; a_byteen = be;
        a_address = aa; a_data = ad; b_address = ba;
        e.tag = tag; e.a0 = '0; e.a1 = '0; e.b = '0;
        e.la_en = lit_a_en; e.la0 = lit_a0; e.la1 = lit_a1;
        e.lb_en = lit_b_en; e.lb = lit_b;
        lit_a_en = 1'b0; lit_b_en = 1'b0;
        if (rst) begin
            nclear = 1'b1;
            m_cnt  = 0;
        end else if (m_clear) begin
            mdl[m_cnt] = FILL;
            nclear = (m_cnt != DEPTH - 1);
            m_cnt  = (m_cnt + 1) % DEPTH;
        end else begin
            old = mdl[aa];
            mrg = old;
            if (be[0]) mrg[7:0]  = ad[7:0];
            if (be[1]) mrg[15:8] = ad[15:8];
            e.b  = mdl[ba];
            e.a1 = old;
            e.a0 = we ? mrg : old;
            if (we) mdl[aa] = mrg;
            nclear = clr;
            if (clr) m_cnt = 0;
        end
`ifdef RAM_DP_CLR_OUTREG_EN
        if (nclear) begin e.a0 = '0; e.a1 = '0; e.b = '0; end
`endif
        m_clear = nclear;
        sb.push_back(e);
        @(posedge clock);
        #1;
        chk({tag, " busy0"}, DW'(busy0), DW'(m_clear));
        chk({tag, " busy1"}, DW'(busy1), DW'(m_clear));
        if (sb.size() >= LAT) begin
            e = sb.pop_front();
`ifdef RAM_DP_CLR_OUTREG_EN
            if (rst) begin e.a0 = '0; e.a1 = '0; e.b = '0; e.la_en = 1'b0; e.lb_en = 1'b0; end
`endif
            chk({e.tag, " a_q0"}, a_q0, e.a0);
            chk({e.tag, " a_q1"}, a_q1, e.a1);
            chk({e.tag, " b_q0"}, b_q0, e.b);
            chk({e.tag, " b_q1"}, b_q1, e.b);
            if (e.la_en) begin
                chk({e.tag, " lit a_q0"}, a_q0, e.la0);
                chk({e.tag, " lit a_q1"}, a_q1, e.la1);
            end
            if (e.lb_en) begin
                chk({e.tag, " lit b_q0"}, b_q0, e.lb);
                chk({e.tag, " lit b_q1"}, b_q1, e.lb);
            end
        end
    endtask

    // Step until busy drops (bounded); n counts the steps taken, including the one where it fell
    task automatic run_clear(input bit we, input string tag, output int n);
        n = 0;
        while (n < 5000) begin
            step(1'b0, 1'b0, we, 2'b11, AW'(11'h7FF), 16'h003C, AW'(n), tag);
            n++;
            if (busy0 === 1'b0) break;
        end
    endtask

    task automatic expect_b(input logic [DW-1:0] v);
        lit_b_en = 1'b1; lit_b = v;
    endtask

    task automatic expect_a(input logic [DW-1:0] v0, input logic [DW-1:0] v1);
        lit_a_en = 1'b1; lit_a0 = v0; lit_a1 = v1;
    endtask

    initial begin
        int n;
        repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, '0, "reset");
        chk("reset a_q0", a_q0, '0);
        chk("reset b_q0", b_q0, '0);

        run_clear(1'b0, "clr_boot", n);
        chk("boot clear length", DW'(n), DW'(2048));

        expect_b(16'h00A5); step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, AW'(0),    "fill rd 0");
        expect_b(16'h00A5); step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, AW'(1023), "fill rd 1023");
        expect_b(16'h00A5); step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, AW'(2047), "fill rd 2047");

        step(1'b0, 1'b0, 1'b1, 2'b11, AW'(16), 16'h1234, '0, "wr 010");
        step(1'b0, 1'b0, 1'b1, 2'b01, AW'(16), 16'hABCD, '0, "lane wr 010");
        expect_a(16'h12CD, 16'h12CD); expect_b(16'h12CD);
        step(1'b0, 1'b0, 1'b0, 2'b00, AW'(16), '0, AW'(16), "lane rd 010");

        step(1'b0, 1'b0, 1'b1, 2'b11, AW'(32), 16'h0F0F, '0, "wr 020");
        expect_a(16'h5555, 16'h0F0F);
        step(1'b0, 1'b0, 1'b1, 2'b11, AW'(32), 16'h5555, '0, "rdw 020");

        step(1'b0, 1'b0, 1'b1, 2'b00, AW'(48), 16'hFFFF, '0, "be0 wr 030");
        expect_b(16'h00A5);
        step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, AW'(48), "be0 rd 030");

        step(1'b0, 1'b0, 1'b1, 2'b11, AW'(256), 16'h0011, '0, "wr 100");
        expect_b(16'h0011);
        step(1'b0, 1'b0, 1'b1, 2'b11, AW'(256), 16'h0077, AW'(256), "collide 100");
        expect_b(16'h0077);
        step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, AW'(256), "after collide");

        step(1'b0, 1'b1, 1'b0, 2'b00, '0, '0, '0, "clr_req");
        run_clear(1'b1, "clr_wr", n);
        chk("req clear length", DW'(n), DW'(2048));
        expect_a(16'h00A5, 16'h00A5); expect_b(16'h00A5);
        step(1'b0, 1'b0, 1'b0, 2'b00, AW'(2047), '0, AW'(2047), "rd 7FF");

        step(1'b0, 1'b1, 1'b0, 2'b00, '0, '0, '0, "clr_req 2");
        repeat (1000) step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0, "clr_mid");
        step(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, '0, "reset mid");
        run_clear(1'b0, "clr_restart", n);
        chk("restart clear length", DW'(n), DW'(2048));
        expect_a(16'h00A5, 16'h00A5); expect_b(16'h00A5);
        step(1'b0, 1'b0, 1'b0, 2'b00, AW'(512), '0, AW'(512), "first rd");
        repeat (2) step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0, "flush");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised successor to the team's single-port write-through block RAM.
- Port A is read/write with byte enables and a selectable read-during-write mode. Port B is an independent read-only port.
- A built-in clear sequencer fills the whole array with a constant after reset or on request.
- Used for video/sprite RAMs that the CPU writes on port A while the video path scans on port B, and that must power up to a known state.

Parameters:
- ADDR_WIDTH, 11, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, lane width; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RDW_MODE, 0, port A read-during-write: 0 = a_q shows the new merged word, 1 = a_q shows the old word.
- FILL_VALUE, 0, DATA_WIDTH-bit word written to every location by the clear sequencer.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clr_req  in  1  one-cycle pulse; requests a full clear.
- busy  out  1  high while the array is being cleared.
- a_address  in  ADDR_WIDTH  port A address.
- a_data  in  DATA_WIDTH  port A write data.
- a_wren  in  1  port A write enable.
- a_byteen  in  NUM_BYTES  port A lane enables; bit i gates bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- a_q  out  DATA_WIDTH  port A read data.
- b_address  in  ADDR_WIDTH  port B address.
- b_q  out  DATA_WIDTH  port B read data.

Behaviour:
- Reset:
  - Any edge with reset=1 sets a_q=0, b_q=0, busy=1, clear counter=0, state=CLEAR.
  - Array contents are not touched during reset.
  - Reset asserted mid-clear restarts the clear from address 0.
- State CLEAR:
  - Each edge writes FILL_VALUE to ram[cnt], then cnt increments.
  - On the edge that writes address 2**ADDR_WIDTH-1, state goes to IDLE and busy=0 from the next cycle. The clear takes exactly 2**ADDR_WIDTH cycles after reset drops.
  - a_wren, a_byteen and clr_req are ignored.
  - a_q and b_q hold 0.
- State IDLE:
  - busy=0.
  - clr_req=1 sets state=CLEAR, cnt=0, busy=1 on the next edge.
  - Port operations on the same edge as clr_req are still performed.
- Port A, IDLE only, latency 1:
  - a_wren=1: lanes with a_byteen[i]=1 take a_data; other lanes keep their old value.
  - a_wren=1 with a_byteen all 0 writes nothing.
  - a_q on a write: RDW_MODE 0 gives the merged word; RDW_MODE 1 gives the pre-write word.
  - a_wren=0: a_q = ram[a_address] of the previous edge.
- Port B, latency 1:
  - b_q = ram[b_address] as sampled on the edge.
  - If A writes the same address on the same edge, b_q returns the old word, regardless of RDW_MODE.
- Addresses wrap naturally; there is no out-of-range case.
- Outputs are registered only; there are no combinational input-to-output paths.

Optional Feature:
- Macro: RAM_DP_CLR_OUTREG_EN.
- Defined: an extra register stage on a_q and b_q. Read latency becomes 2 cycles. The stage resets to 0 and holds 0 while busy. Write and clear timing are unchanged.
- Undefined: latency 1 as above.

Test Plan:
- Clear after reset: hold reset 3 cycles, FILL_VALUE=8'hA5.
  - busy stays high exactly 2048 cycles after reset drops.
  - Then reading addresses 0, 1023 and 2047 on B gives 8'hA5 one cycle later.
- Byte-lane write, DATA_WIDTH=16, BYTE_WIDTH=8:
  - Location 0x010 holds 16'h1234; write 16'hABCD with a_byteen=2'b01.
  - Subsequent read of 0x010 gives 16'h12CD.
- Read-during-write: write 16'h5555 to 0x020, which holds 16'h0F0F, byteen=2'b11.
  - RDW_MODE=0 gives a_q=16'h5555 next cycle; RDW_MODE=1 gives a_q=16'h0F0F.
- Port collision: same edge, A writes 8'h77 to 0x100 (old 8'h11) and B reads 0x100.
  - b_q=8'h11.
  - B read of 0x100 on the following edge gives 8'h77.
- Writes ignored during clear:
  - clr_req pulse in IDLE makes busy go high next cycle.
  - a_wren=1 at 0x7FF with 8'h3C during clear is ignored.
  - After busy falls, 0x7FF reads FILL_VALUE.
- Reset mid-clear: reset pulse at clear cycle 1000.
  - busy stays high for 2048 cycles after reset drops.
  - a_q and b_q stay 0 throughout.
  - With RAM_DP_CLR_OUTREG_EN defined, the first valid B read after busy falls appears 2 cycles after its address.
